video_pattern_gen: RTL and testbench

//  AXI-Stream RGB565 video source: emits whole frames of a selectable test pattern
//  (colour bars, checkerboard, gradient, solid) with SOF on tuser and EOL on tlast.

---
 rtl/video_pattern_gen_pkg.sv | 48 ++++
 rtl/video_pattern_gen_pixel.sv | 40 ++++
 rtl/video_pattern_gen.sv | 130 +++++++++++++
 tb/tb_video_pattern_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_gen_pkg.sv
// Shared definitions for the video pattern generator.
// Contents: pattern mode encodings, FSM states, RGB565 colour constants,
// the XGA active/total timing shared with the downstream video output
// stage, and the colour-bar lookup.
package video_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_SOLID    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // RGB565 {r[15:11], g[10:5], b[4:0]}
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // 1024x768 timing, kept identical to the video output stage
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_H_TOTAL  = 1344;
  localparam int XGA_V_TOTAL  = 806;

  function automatic logic [15:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_color = RGB_WHITE;
      3'd1:    bar_color = RGB_YELLOW;
      3'd2:    bar_color = RGB_CYAN;
      3'd3:    bar_color = RGB_GREEN;
      3'd4:    bar_color = RGB_MAGENTA;
      3'd5:    bar_color = RGB_RED;
      3'd6:    bar_color = RGB_BLUE;
      default: bar_color = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_gen_pixel.sv
// Combinational pattern pixel: (mode, x, y, solid colour) -> RGB565.
// Ports:
//   mode   in  2      pattern select (bars/checker/gradient/solid)
//   x, y   in  CNT_W  coordinate of the pixel being produced
//   solid  in  16     colour used by the solid pattern
//   pixel  out 16     RGB565 result
module video_pattern_gen_pixel #(
  parameter int H_ACTIVE = 1024,
  parameter int CHK_LOG2 = 5,
  parameter int CNT_W    = 12
) (
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [15:0]      solid,
  output logic [15:0]      pixel
);
  import video_pattern_gen_pkg::*;

  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

  logic [CNT_W-1:0] bar_idx;
  assign bar_idx = x / BAR_W;

  // Bits that no pattern looks at; gathered here to keep lint quiet.
  logic unused_bits;
  assign unused_bits = ^{bar_idx[CNT_W-1:3], y[CNT_W-1:6]};

  always_comb begin
    pixel = RGB_BLACK;
    case (mode_e'(mode))
      MODE_BARS:     pixel = bar_color(bar_idx[2:0]);
      MODE_CHECKER:  pixel = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? RGB_WHITE : RGB_BLACK;
      MODE_GRADIENT: pixel = {x[4:0], y[5:0], x[9:5]};
      MODE_SOLID:    pixel = solid;
      default:       pixel = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI-Stream RGB565 test-pattern source. Emits whole frames with SOF on
// tuser_m and EOL on tlast_m; pattern and colour are latched at SOF.
// Ports:
//   clk, reset    pixel clock, synchronous active-high reset
//   enable        start/continue frames; only looked at on frame boundaries
//   mode_sel      pattern select, latched at SOF
//   solid_color   colour for the solid pattern, latched at SOF
//   tdata_m/tuser_m/tlast_m/tvalid_m/tready_m  AXI-Stream master
//   frame_done    one-cycle pulse after the last pixel of a frame is accepted
//   frame_count   frames completed since reset (wraps)
module video_pattern_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int CHK_LOG2 = 5,
  parameter int CNT_W    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode_sel,
  input  logic [15:0] solid_color,
  output logic [15:0] tdata_m,
  output logic        tuser_m,
  output logic        tlast_m,
  output logic        tvalid_m,
  input  logic        tready_m,
  output logic        frame_done,
  output logic [15:0] frame_count
);
  import video_pattern_gen_pkg::*;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  state_e           state_reg;
  logic [CNT_W-1:0] x_reg, y_reg, x_next, y_next;
  logic [1:0]       mode_reg, mode_next;
  logic [15:0]      solid_reg, solid_next;
  logic [15:0]      tdata_reg;
  logic             tuser_reg, tlast_reg, tvalid_reg, frame_done_reg;
  logic [15:0]      frame_count_reg;
  logic [15:0]      pix_next;

  logic transfer, frame_end, sof_load, load_beat, drop_valid;

  // x_reg/y_reg track the pixel currently presented; x_next/y_next the one
  // to present after this cycle. The pixel for x_next/y_next is computed
  // now and registered, so a fresh beat follows every transfer.
  always_comb begin
    transfer   = tvalid_reg & tready_m;
    frame_end  = transfer & (x_reg == X_LAST) & (y_reg == Y_LAST);
    sof_load   = ((state_reg == ST_IDLE) | frame_end) & enable;
    load_beat  = sof_load | (transfer & ~frame_end);
    drop_valid = frame_end & ~enable;

    x_next = x_reg;
    y_next = y_reg;
    if (state_reg == ST_IDLE) begin
      x_next = '0;
      y_next = '0;
    end else if (transfer) begin
      if (x_reg == X_LAST) begin
        x_next = '0;
        y_next = (y_reg == Y_LAST) ? '0 : y_reg + CNT_W'(1);
      end else begin
        x_next = x_reg + CNT_W'(1);
      end
    end

    mode_next  = sof_load ? mode_sel : mode_reg;
    solid_next = sof_load ? solid_color : solid_reg;
  end

  video_pattern_gen_pixel #(
    .H_ACTIVE (H_ACTIVE),
    .CHK_LOG2 (CHK_LOG2),
    .CNT_W    (CNT_W)
  ) u_pixel (
    .mode  (mode_next),
    .x     (x_next),
    .y     (y_next),
    .solid (solid_next),
    .pixel (pix_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      x_reg           <= '0;
      y_reg           <= '0;
      mode_reg        <= '0;
      solid_reg       <= '0;
      tdata_reg       <= '0;
      tuser_reg       <= 1'b0;
      tlast_reg       <= 1'b0;
      tvalid_reg      <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      x_reg          <= x_next;
      y_reg          <= y_next;
      mode_reg       <= mode_next;
      solid_reg      <= solid_next;
      frame_done_reg <= frame_end;
      if (frame_end)
        frame_count_reg <= frame_count_reg + 16'd1;

      if (load_beat) begin
        state_reg  <= ST_ACTIVE;
        tvalid_reg <= 1'b1;
        tdata_reg  <= pix_next;
        tuser_reg  <= (x_next == '0) && (y_next == '0);
        tlast_reg  <= (x_next == X_LAST);
      end else if (drop_valid) begin
        state_reg  <= ST_IDLE;
        tvalid_reg <= 1'b0;
        tuser_reg  <= 1'b0;
        tlast_reg  <= 1'b0;
      end
    end
  end

  assign tdata_m     = tdata_reg;
  assign tuser_m     = tuser_reg;
  assign tlast_m     = tlast_reg;
  assign tvalid_m    = tvalid_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_video_pattern_gen.sv
module tb_video_pattern_gen;

  localparam int H = 16;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic [15:0] tdata_m;
  logic        tuser_m, tlast_m, tvalid_m;
  logic        tready_m = 1'b1;
  logic        frame_done;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .CHK_LOG2 (1),
    .CNT_W    (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode_sel    (mode_sel),
    .solid_color (solid_color),
    .tdata_m     (tdata_m),
    .tuser_m     (tuser_m),
    .tlast_m     (tlast_m),
    .tvalid_m    (tvalid_m),
    .tready_m    (tready_m),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        u;
    logic        l;
    logic        f;   // last pixel of the frame
  } beat_t;

  beat_t q[$];
  int    total = 0;
  int    bad = 0;
  int    beat_cnt = 0;
  logic  exp_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pix(input int mode, input logic [15:0] col,
                                            input int x, input int y);
    logic [11:0] xv, yv;
    xv = 12'(x);
    yv = 12'(y);
    case (mode)
      0: begin
        case (x / (H / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      1: return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      2: return {xv[4:0], yv[5:0], xv[9:5]};
      default: return col;
    endcase
  endfunction

  task automatic push_frame(input int mode, input logic [15:0] col);
    beat_t b;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        b.d = model_pix(mode, col, x, y);
        b.u = (x == 0) && (y == 0);
        b.l = (x == H - 1);
        b.f = (x == H - 1) && (y == V - 1);
        q.push_back(b);
      end
  endtask

  // Monitor: compare the presented beat with the scoreboard head every
  // cycle it is valid (covers stability under backpressure); pop on transfer.
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 1'b0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(exp_done));
      exp_done = 1'b0;
      if (tvalid_m) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 32'(tvalid_m), 32'd0);
        end else begin
          check("tdata", 32'(tdata_m), 32'(q[0].d));
          check("tuser", 32'(tuser_m), 32'(q[0].u));
          check("tlast", 32'(tlast_m), 32'(q[0].l));
          if (tready_m) begin
            exp_done = q[0].f;
            void'(q.pop_front());
            beat_cnt++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    tready_m = 1'b1;
    repeat (3) tick();
    q.delete();
    check("rst_tvalid", 32'(tvalid_m), 32'd0);
    check("rst_tuser", 32'(tuser_m), 32'd0);
    check("rst_tlast", 32'(tlast_m), 32'd0);
    check("rst_tdata", 32'(tdata_m), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_beats(input int base, input int n);
    int c;
    for (c = 0; c < 2000; c++) begin
      if (beat_cnt - base >= n) break;
      tick();
    end
    if (c == 2000) check("wait_beats_timeout", 32'(beat_cnt - base), 32'(n));
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; c < 3000; c++) begin
      if (q.size() == 0 && !tvalid_m) break;
      tick();
    end
    if (c == 3000) check("idle_timeout", 32'(q.size()), 32'd0);
    repeat (3) tick();
    check("idle_tvalid", 32'(tvalid_m), 32'd0);
    check("idle_queue", 32'(q.size()), 32'd0);
  endtask

  // Start a single frame: enable for exactly one sampling cycle.
  task automatic start_frame(input int mode, input logic [15:0] col, input logic hold_enable);
    mode_sel = 2'(mode);
    solid_color = col;
    push_frame(mode, col);
    enable = 1'b1;
    tick();
    check("start_tvalid", 32'(tvalid_m), 32'd1);
    check("start_tuser", 32'(tuser_m), 32'd1);
    if (!hold_enable) enable = 1'b0;
  endtask

  initial begin
    int base;
    logic stalled;

    // 1: colour bars, full throughput
    do_reset();
    check("idle_before_enable", 32'(tvalid_m), 32'd0);
    base = beat_cnt;
    start_frame(0, 16'h0000, 1'b0);
    wait_idle();
    check("t1_beats", 32'(beat_cnt - base), 32'd64);
    check("t1_frame_count", 32'(frame_count), 32'd1);
    $display("t1 bars: beats=%0d frame_count=%0d", beat_cnt - base, frame_count);

    // 2: checkerboard
    do_reset();
    base = beat_cnt;
    start_frame(1, 16'h0000, 1'b0);
    wait_idle();
    check("t2_beats", 32'(beat_cnt - base), 32'd64);
    $display("t2 checker: beats=%0d", beat_cnt - base);

    // 3: solid under random backpressure with a long stall at x=7
    do_reset();
    base = beat_cnt;
    start_frame(3, 16'h1234, 1'b0);
    stalled = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!stalled && (beat_cnt - base == 7)) begin
        tready_m = 1'b0;
        repeat (20) tick();
        stalled = 1'b1;
      end else begin
        tready_m = 1'($urandom_range(0, 1));
      end
      tick();
      if (q.size() == 0 && !tvalid_m) break;
    end
    tready_m = 1'b1;
    wait_idle();
    check("t3_beats", 32'(beat_cnt - base), 32'd64);
    check("t3_frame_count", 32'(frame_count), 32'd1);
    $display("t3 solid+stall: beats=%0d frame_count=%0d", beat_cnt - base, frame_count);

    // 4: mode change mid-frame takes effect at next SOF
    do_reset();
    base = beat_cnt;
    start_frame(3, 16'h00AA, 1'b1);
    wait_beats(base, 20);
    mode_sel = 2'd0;
    push_frame(0, 16'h00AA);
    wait_beats(base, 70);
    enable = 1'b0;
    wait_idle();
    check("t4_beats", 32'(beat_cnt - base), 32'd128);
    check("t4_frame_count", 32'(frame_count), 32'd2);
    $display("t4 mode switch: beats=%0d frame_count=%0d", beat_cnt - base, frame_count);

    // 5: enable dropped mid-frame, frame still completes
    do_reset();
    base = beat_cnt;
    start_frame(2, 16'h0000, 1'b1);
    wait_beats(base, 30);
    enable = 1'b0;
    wait_idle();
    check("t5_beats", 32'(beat_cnt - base), 32'd64);
    check("t5_frame_count", 32'(frame_count), 32'd1);
    $display("t5 enable drop: beats=%0d frame_count=%0d", beat_cnt - base, frame_count);

    // 6: reset mid-frame aborts; restart at (0,0)
    base = beat_cnt;
    start_frame(0, 16'h0000, 1'b1);
    wait_beats(base, 40);
    reset = 1'b1;
    enable = 1'b0;
    tick();
    check("t6_rst_tvalid", 32'(tvalid_m), 32'd0);
    check("t6_rst_frame_count", 32'(frame_count), 32'd0);
    q.delete();
    reset = 1'b0;
    tick();
    base = beat_cnt;
    start_frame(1, 16'h0000, 1'b0);
    wait_idle();
    check("t6_beats", 32'(beat_cnt - base), 32'd64);
    check("t6_frame_count", 32'(frame_count), 32'd1);
    $display("t6 reset abort: beats=%0d frame_count=%0d", beat_cnt - base, frame_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
